// File: rtl/vram_burst_reader_if.sv
// Bus bundle for vram_burst_reader: the command/status signals, the arbiter
// read slot and the FIFO drain stream.
// The optional stride input is present only when VRAM_BURST_STRIDE_EN is defined.
interface vram_burst_reader_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic [14:0]      start_addr;
    logic [CNT_W-1:0] word_count;
    logic             abort;
    logic             busy;
    logic             done;
    logic [14:0]      vram_addr;
    logic             vram_strobe;
    logic             vram_ack;
    logic [31:0]      vram_rddata;
    logic [31:0]      out_data;
    logic             out_valid;
    logic             out_ready;
`ifdef VRAM_BURST_STRIDE_EN
    logic [7:0]       stride;

    modport slave (
        input  start, start_addr, word_count, abort, stride,
        input  vram_ack, vram_rddata, out_ready,
        output busy, done, vram_addr, vram_strobe, out_data, out_valid
    );

    modport master (
        output start, start_addr, word_count, abort, stride,
        output vram_ack, vram_rddata, out_ready,
        input  busy, done, vram_addr, vram_strobe, out_data, out_valid
    );
`else
    modport slave (
        input  start, start_addr, word_count, abort,
        input  vram_ack, vram_rddata, out_ready,
        output busy, done, vram_addr, vram_strobe, out_data, out_valid
    );

    modport master (
        output start, start_addr, word_count, abort,
        output vram_ack, vram_rddata, out_ready,
        input  busy, done, vram_addr, vram_strobe, out_data, out_valid
    );
`endif
endinterface

// File: rtl/vram_burst_reader.sv
// vram_burst_reader: fetches a run of consecutive 32-bit VRAM words through
// one arbiter read slot into a first-word-fall-through FIFO. The renderer
// drains that FIFO with a valid/ready handshake.
// Optional feature macro: VRAM_BURST_STRIDE_EN. It adds a per-burst address
// stride that is latched on start. Without the macro the stride is fixed at 1.
module vram_burst_reader #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    vram_burst_reader_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t            state, state_nxt;
    logic [14:0]       cur_addr;
    logic [14:0]       incr;
    logic [CNT_W:0]    remaining;
    logic [CNT_W:0]    remaining_after;
    logic [31:0]       mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       level;
    logic              discard;
    logic              ack_eff;
    logic              push, pop;
    logic              fifo_nonempty;
    logic              done_c;

`ifdef VRAM_BURST_STRIDE_EN
    logic [7:0]        stride_q;
    assign incr = {7'd0, stride_q};
`else
    assign incr = 15'd1;
`endif

    // An ack counts only while fetching. The ack that may trail an abort is
    // dropped by the discard flag.
    assign ack_eff         = bus.vram_ack && (state == FETCH) && !discard && (remaining != '0);
    assign push            = ack_eff;
    assign fifo_nonempty   = (level != '0);
    assign pop             = fifo_nonempty && bus.out_ready;
    assign remaining_after = remaining - {{CNT_W{1'b0}}, ack_eff};

    // The level bound leaves room for the one request that may be in flight.
    assign bus.vram_strobe = (state == FETCH) && (remaining_after != '0)
                             && (level <= (AW+1)'(DEPTH - 2));
    assign bus.vram_addr   = cur_addr + (ack_eff ? incr : 15'd0);
    assign bus.busy        = (state != IDLE);
    assign bus.done        = done_c;
    assign bus.out_valid   = fifo_nonempty;
    assign bus.out_data    = fifo_nonempty ? mem[rd_ptr] : 32'd0;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic and the done pulse. Abort overrides everything.
    always_comb begin
        state_nxt = state;
        done_c    = 1'b0;
        unique case (state)
            IDLE:  if (bus.start) state_nxt = FETCH;
            FETCH: if (ack_eff && remaining == (CNT_W+1)'(1)) state_nxt = DRAIN;
            DRAIN: if (pop && level == (AW+1)'(1)) begin
                       state_nxt = IDLE;
                       done_c    = 1'b1;
                   end
            default: state_nxt = IDLE;
        endcase
        if (bus.abort) begin
            state_nxt = IDLE;
            done_c    = 1'b0;
        end
    end

    // Burst address and word counter, plus the post-abort discard flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_addr  <= '0;
            remaining <= '0;
            discard   <= 1'b0;
`ifdef VRAM_BURST_STRIDE_EN
            stride_q  <= '0;
`endif
        end else begin
            discard <= bus.abort;
            if (bus.abort) begin
                remaining <= '0;
            end else if (state == IDLE && bus.start) begin
                cur_addr  <= bus.start_addr;
                remaining <= (bus.word_count == '0) ? {1'b1, {CNT_W{1'b0}}}
                                                    : {1'b0, bus.word_count};
`ifdef VRAM_BURST_STRIDE_EN
                stride_q  <= bus.stride;
`endif
            end else if (ack_eff) begin
                cur_addr  <= cur_addr + incr;
                remaining <= remaining - (CNT_W+1)'(1);
            end
        end
    end

    // FIFO pointers and occupancy. Abort flushes by clearing them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (bus.abort) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // FIFO storage. It has no reset because out_data is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.vram_rddata;
    end
endmodule
